// File: rtl/mpram_pkg.sv
// Shared types and elaboration helpers for the mixed-width dual-port RAM.
// Covers the clear-engine state encoding, the address/lane width derivation and the collision counter width.
package mpram_pkg;

  localparam int COLL_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int b_depth(input int a_depth, input int ratio);
    return a_depth / ratio;
  endfunction

  function automatic int lane_bits(input int ratio);
    return $clog2(ratio);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/mpram_rd_pipe.sv
// Read-return pipeline for one RAM port: data/valid delayed by STAGES (1 or 2) cycles.
// Data only loads when its valid is set, so readdata holds between returns.
module mpram_rd_pipe #(
  parameter int DATA_W = 128,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              vld_out,
  output logic [DATA_W-1:0] data_out
);

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;

  // Stage p0: capture the array read at the accepting edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= vld_in;
      if (vld_in) data_p0 <= data_in;
    end
  end

  if (STAGES == 2) begin : g_p1
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    // Stage p1: optional output register
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) data_p1 <= data_p0;
      end
    end

    assign vld_out  = vld_p1;
    assign data_out = data_p1;
  end else begin : g_p0_out
    assign vld_out  = vld_p0;
    assign data_out = data_p0;
  end

endmodule

// File: rtl/mixed_width_dpram_clr.sv
// True dual-port RAM with narrow port A, wide port B, byte enables and a zero-fill engine.
// Define MPRAM_COLLISION_STAT_EN to build the same-word write-collision counter.
module mixed_width_dpram_clr
  import mpram_pkg::*;
#(
  parameter int A_DATA_W     = 128,
  parameter int B_RATIO      = 2,
  parameter int A_DEPTH      = 4096,
  parameter int READ_LATENCY = 1
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [addr_w(A_DEPTH)-1:0]                a_address,
  input  logic                                      a_chipselect,
  input  logic                                      a_read,
  input  logic                                      a_write,
  input  logic [A_DATA_W/8-1:0]                     a_byteenable,
  input  logic [A_DATA_W-1:0]                       a_writedata,
  output logic [A_DATA_W-1:0]                       a_readdata,
  output logic                                      a_readdatavalid,
  output logic                                      a_waitrequest,
  input  logic [addr_w(b_depth(A_DEPTH, B_RATIO))-1:0] b_address,
  input  logic                                      b_chipselect,
  input  logic                                      b_read,
  input  logic                                      b_write,
  input  logic [A_DATA_W*B_RATIO/8-1:0]             b_byteenable,
  input  logic [A_DATA_W*B_RATIO-1:0]               b_writedata,
  output logic [A_DATA_W*B_RATIO-1:0]               b_readdata,
  output logic                                      b_readdatavalid,
  output logic                                      b_waitrequest,
  input  logic                                      clear_req,
  output logic                                      clear_busy,
  output logic                                      clear_done,
  output logic [COLL_CNT_W-1:0]                     collision_count
);

  localparam int B_DEPTH   = b_depth(A_DEPTH, B_RATIO);
  localparam int B_W       = A_DATA_W * B_RATIO;
  localparam int A_BYTES   = A_DATA_W / 8;
  localparam int B_BYTES   = B_W / 8;
  localparam int AAW       = addr_w(A_DEPTH);
  localparam int BAW       = addr_w(B_DEPTH);
  localparam int LANE_BITS = lane_bits(B_RATIO);
  localparam int LANE_W    = (B_RATIO > 1) ? LANE_BITS : 1;

  if (A_DATA_W < 8 || (A_DATA_W % 8) != 0) begin : g_bad_a_data_w
    $fatal(1, "A_DATA_W must be a positive multiple of 8");
  end
  if (!is_pow2(B_RATIO) || B_RATIO > 8) begin : g_bad_b_ratio
    $fatal(1, "B_RATIO must be a power of 2 in 1..8");
  end
  if (!is_pow2(A_DEPTH) || A_DEPTH < 2 * B_RATIO) begin : g_bad_a_depth
    $fatal(1, "A_DEPTH must be a power of 2 giving at least two port B words");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
    $fatal(1, "READ_LATENCY must be 1 or 2");
  end

  clr_state_t      state, state_nxt;
  logic [BAW-1:0]  ptr, ptr_nxt;
  logic            clr_we;

  logic            a_wr, a_rd, b_wr, b_rd;
  logic [BAW-1:0]  a_word;
  logic [LANE_W-1:0] a_lane;
  logic [B_BYTES-1:0] a_be_wide;
  logic [B_W-1:0]  a_wd_wide;
  logic [B_W-1:0]  a_rd_word;
  logic [A_DATA_W-1:0] a_rd_lane;
  logic [B_W-1:0]  b_rd_word;

  logic [B_W-1:0]  mem [B_DEPTH];

  // Host ports share a single stall: nothing is accepted while the array is being zeroed.
  assign a_waitrequest = clear_busy;
  assign b_waitrequest = clear_busy;

  // Read and write together means write only.
  assign a_wr = a_chipselect && a_write && !a_waitrequest;
  assign a_rd = a_chipselect && a_read && !a_write && !a_waitrequest;
  assign b_wr = b_chipselect && b_write && !b_waitrequest;
  assign b_rd = b_chipselect && b_read && !b_write && !b_waitrequest;

  assign a_word    = BAW'(a_address >> LANE_BITS);
  assign a_lane    = LANE_W'(a_address & AAW'(B_RATIO - 1));
  assign a_be_wide = B_BYTES'(a_byteenable) << (A_BYTES * a_lane);
  assign a_wd_wide = {B_RATIO{a_writedata}};

  assign a_rd_word = mem[a_word];
  assign a_rd_lane = a_rd_word[A_DATA_W*a_lane +: A_DATA_W];
  assign b_rd_word = mem[b_address];

  // Port A is applied after port B so it owns overlapping bytes; reads see pre-edge contents.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr] <= '0;
    end else begin
      for (int i = 0; i < B_BYTES; i++) begin
        if (b_wr && b_byteenable[i]) mem[b_address][8*i +: 8] <= b_writedata[8*i +: 8];
      end
      for (int i = 0; i < B_BYTES; i++) begin
        if (a_wr && a_be_wide[i]) mem[a_word][8*i +: 8] <= a_wd_wide[8*i +: 8];
      end
    end
  end

  mpram_rd_pipe #(
    .DATA_W (A_DATA_W),
    .STAGES (READ_LATENCY)
  ) u_a_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .vld_in   (a_rd),
    .data_in  (a_rd_lane),
    .vld_out  (a_readdatavalid),
    .data_out (a_readdata)
  );

  mpram_rd_pipe #(
    .DATA_W (B_W),
    .STAGES (READ_LATENCY)
  ) u_b_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .vld_in   (b_rd),
    .data_in  (b_rd_word),
    .vld_out  (b_readdatavalid),
    .data_out (b_readdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Busy rises combinationally with clear_req so no command slips in on the start cycle.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    clr_we     = 1'b0;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt  = CLEAR;
          ptr_nxt    = '0;
          clear_busy = 1'b1;
        end
      end
      CLEAR: begin
        clear_busy = 1'b1;
        clr_we     = 1'b1;
        ptr_nxt    = ptr + 1'b1;
        if (ptr == BAW'(B_DEPTH - 1)) begin
          state_nxt = DONE;
          ptr_nxt   = '0;
        end
      end
      DONE: begin
        clear_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MPRAM_COLLISION_STAT_EN
  logic                  collide;
  logic [COLL_CNT_W-1:0] coll_cnt;

  assign collide = a_wr && b_wr && (a_word == b_address) && (|(a_be_wide & b_byteenable));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coll_cnt <= '0;
    end else if (state == IDLE && clear_req) begin
      coll_cnt <= '0;
    end else if (collide && coll_cnt != '1) begin
      coll_cnt <= coll_cnt + 1'b1;
    end
  end

  assign collision_count = coll_cnt;
`else
  assign collision_count = '0;
`endif

endmodule

// File: tb/tb_mixed_width_dpram_clr.sv
// Bench for mixed_width_dpram_clr: directed steps plus random traffic against a byte-addressed reference model.
// Honours MPRAM_COLLISION_STAT_EN for the expected collision count.
module tb_mixed_width_dpram_clr;

  localparam int A_DATA_W     = 128;
  localparam int B_RATIO      = 2;
  localparam int A_DEPTH      = 256;
  localparam int READ_LATENCY = 2;
  localparam int B_DEPTH      = A_DEPTH / B_RATIO;
  localparam int B_W          = A_DATA_W * B_RATIO;
  localparam int A_BYTES      = A_DATA_W / 8;
  localparam int B_BYTES      = B_W / 8;
  localparam int AAW          = $clog2(A_DEPTH);
  localparam int BAW          = $clog2(B_DEPTH);

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [AAW-1:0]      a_address = '0;
  logic                a_chipselect = 1'b0, a_read = 1'b0, a_write = 1'b0;
  logic [A_BYTES-1:0]  a_byteenable = '0;
  logic [A_DATA_W-1:0] a_writedata = '0;
  logic [A_DATA_W-1:0] a_readdata;
  logic                a_readdatavalid, a_waitrequest;
  logic [BAW-1:0]      b_address = '0;
  logic                b_chipselect = 1'b0, b_read = 1'b0, b_write = 1'b0;
  logic [B_BYTES-1:0]  b_byteenable = '0;
  logic [B_W-1:0]      b_writedata = '0;
  logic [B_W-1:0]      b_readdata;
  logic                b_readdatavalid, b_waitrequest;
  logic                clear_req = 1'b0;
  logic                clear_busy, clear_done;
  logic [15:0]         collision_count;

  always #5 clk = ~clk;

  mixed_width_dpram_clr #(
    .A_DATA_W     (A_DATA_W),
    .B_RATIO      (B_RATIO),
    .A_DEPTH      (A_DEPTH),
    .READ_LATENCY (READ_LATENCY)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .a_address       (a_address),
    .a_chipselect    (a_chipselect),
    .a_read          (a_read),
    .a_write         (a_write),
    .a_byteenable    (a_byteenable),
    .a_writedata     (a_writedata),
    .a_readdata      (a_readdata),
    .a_readdatavalid (a_readdatavalid),
    .a_waitrequest   (a_waitrequest),
    .b_address       (b_address),
    .b_chipselect    (b_chipselect),
    .b_read          (b_read),
    .b_write         (b_write),
    .b_byteenable    (b_byteenable),
    .b_writedata     (b_writedata),
    .b_readdata      (b_readdata),
    .b_readdatavalid (b_readdatavalid),
    .b_waitrequest   (b_waitrequest),
    .clear_req       (clear_req),
    .clear_busy      (clear_busy),
    .clear_done      (clear_done),
    .collision_count (collision_count)
  );

  typedef struct {
    int             due;
    logic [B_W-1:0] data;
  } rd_t;

  rd_t         aq[$];
  rd_t         bq[$];
  logic [7:0]  ref_mem [B_DEPTH*B_BYTES];
  int          clr_pos = -1;
  bit          done_pend = 1'b0;
  int          coll = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          dut_wait = 0;
  int          dut_done = 0;
  int          a_vld_seen = 0;

  task automatic chk(input string tag, input logic [B_W-1:0] obs, input logic [B_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [B_W-1:0] ref_read(input int byte_base, input int nbytes);
    logic [B_W-1:0] v;
    v = '0;
    for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_mem[byte_base + i];
    return v;
  endfunction

  function automatic logic [15:0] coll_exp();
`ifdef MPRAM_COLLISION_STAT_EN
    return 16'(coll);
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [A_DATA_W-1:0] rand_a();
    logic [A_DATA_W-1:0] v;
    for (int i = 0; i < A_DATA_W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [B_W-1:0] rand_b();
    logic [B_W-1:0] v;
    for (int i = 0; i < B_W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive_a(input bit cs, input bit rd, input bit wr, input int addr,
                         input logic [A_BYTES-1:0] be, input logic [A_DATA_W-1:0] wd);
    a_chipselect = cs; a_read = rd; a_write = wr;
    a_address = AAW'(addr); a_byteenable = be; a_writedata = wd;
  endtask

  task automatic drive_b(input bit cs, input bit rd, input bit wr, input int addr,
                         input logic [B_BYTES-1:0] be, input logic [B_W-1:0] wd);
    b_chipselect = cs; b_read = rd; b_write = wr;
    b_address = BAW'(addr); b_byteenable = be; b_writedata = wd;
  endtask

  task automatic idle();
    drive_a(0, 0, 0, 0, '0, '0);
    drive_b(0, 0, 0, 0, '0, '0);
  endtask

  // One clock: check stall outputs, update the model from the driven command, then check returns.
  task automatic step();
    bit busy, aw, ar, bw, br, hit, ev;
    int abase, bbase;
    #1;
    busy = (clr_pos >= 0) || (!done_pend && clear_req);
    chk("a_waitrequest", B_W'(a_waitrequest), B_W'(busy));
    chk("b_waitrequest", B_W'(b_waitrequest), B_W'(busy));
    chk("clear_busy", B_W'(clear_busy), B_W'(busy));
    chk("clear_done", B_W'(clear_done), B_W'(done_pend));
    if (a_waitrequest === 1'b1) dut_wait++;
    if (clear_done === 1'b1) dut_done++;
    aw = !busy && a_chipselect && a_write;
    ar = !busy && a_chipselect && a_read && !a_write;
    bw = !busy && b_chipselect && b_write;
    br = !busy && b_chipselect && b_read && !b_write;
    abase = int'(a_address) * A_BYTES;
    bbase = int'(b_address) * B_BYTES;
    if (ar) aq.push_back('{cyc + READ_LATENCY, ref_read(abase, A_BYTES)});
    if (br) bq.push_back('{cyc + READ_LATENCY, ref_read(bbase, B_BYTES)});
    if (aw && bw) begin
      hit = 1'b0;
      for (int i = 0; i < A_BYTES; i++)
        for (int j = 0; j < B_BYTES; j++)
          if (a_byteenable[i] && b_byteenable[j] && (abase + i == bbase + j)) hit = 1'b1;
      if (hit && coll < 16'hFFFF) coll++;
    end
    if (bw) for (int j = 0; j < B_BYTES; j++) if (b_byteenable[j]) ref_mem[bbase + j] = b_writedata[8*j +: 8];
    if (aw) for (int i = 0; i < A_BYTES; i++) if (a_byteenable[i]) ref_mem[abase + i] = a_writedata[8*i +: 8];
    if (clr_pos >= 0) begin
      for (int j = 0; j < B_BYTES; j++) ref_mem[clr_pos*B_BYTES + j] = 8'h00;
      if (clr_pos == B_DEPTH - 1) begin
        clr_pos = -1;
        done_pend = 1'b1;
      end else begin
        clr_pos++;
      end
    end else if (done_pend) begin
      done_pend = 1'b0;
    end else if (clear_req) begin
      clr_pos = 0;
      coll = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    ev = (aq.size() > 0) && (aq[0].due == cyc);
    chk("a_readdatavalid", B_W'(a_readdatavalid), B_W'(ev));
    if (a_readdatavalid === 1'b1) a_vld_seen++;
    if (ev) begin
      chk("a_readdata", B_W'(a_readdata), aq[0].data);
      void'(aq.pop_front());
    end
    ev = (bq.size() > 0) && (bq[0].due == cyc);
    chk("b_readdatavalid", B_W'(b_readdatavalid), B_W'(ev));
    if (ev) begin
      chk("b_readdata", b_readdata, bq[0].data);
      void'(bq.pop_front());
    end
    chk("collision_count", B_W'(collision_count), B_W'(coll_exp()));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_readdata"}, B_W'(a_readdata), '0);
    chk({tag, "_b_readdata"}, b_readdata, '0);
    chk({tag, "_a_readdatavalid"}, B_W'(a_readdatavalid), '0);
    chk({tag, "_b_readdatavalid"}, B_W'(b_readdatavalid), '0);
    chk({tag, "_a_waitrequest"}, B_W'(a_waitrequest), '0);
    chk({tag, "_b_waitrequest"}, B_W'(b_waitrequest), '0);
    chk({tag, "_clear_busy"}, B_W'(clear_busy), '0);
    chk({tag, "_clear_done"}, B_W'(clear_done), '0);
    chk({tag, "_collision_count"}, B_W'(collision_count), '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]    t3_coll;
    logic [B_W-1:0] d, saved10;
    int             guard;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    for (int w = 0; w < B_DEPTH; w++) begin
      drive_b(1, 0, 1, w, '1, rand_b());
      step();
    end
    idle();

    // Narrow write lands in the upper lane of wide word 2
    drive_a(1, 0, 1, 5, '1, {16{8'h11}});
    step();
    idle();
    drive_b(1, 1, 0, 2, '0, '0);
    step();
    idle();
    repeat (READ_LATENCY - 1) step();
    chk("t1_valid", B_W'(b_readdatavalid), B_W'(1'b1));
    chk("t1_upper", B_W'(b_readdata[B_W-1:A_DATA_W]), B_W'({16{8'h11}}));

    // Partial byte-enable write from the wide port
    drive_b(1, 0, 1, 0, '1, {32{8'hFF}});
    step();
    drive_b(1, 0, 1, 0, 32'h0000_000F, '0);
    step();
    idle();
    drive_a(1, 1, 0, 0, '0, '0);
    step();
    idle();
    repeat (READ_LATENCY - 1) step();
    chk("t2_a_word0", B_W'(a_readdata), B_W'({{12{8'hFF}}, 32'h0}));

    // Same-word collision: A owns its lane, B keeps the other
    drive_a(1, 0, 1, 1, '1, {16{8'hAA}});
    drive_b(1, 0, 1, 0, '1, {32{8'hBB}});
    step();
    idle();
`ifdef MPRAM_COLLISION_STAT_EN
    t3_coll = 16'd1;
`else
    t3_coll = 16'd0;
`endif
    chk("t3_collision_count", B_W'(collision_count), B_W'(t3_coll));
    drive_b(1, 1, 0, 0, '0, '0);
    step();
    idle();
    repeat (READ_LATENCY - 1) step();
    chk("t3_word0", b_readdata, {{16{8'hAA}}, {16{8'hBB}}});

    for (int n = 0; n < 400; n++) begin
      drive_a(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), A_BYTES'($urandom), rand_a());
      drive_b(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), B_BYTES'($urandom), rand_b());
      step();
    end
    idle();
    repeat (READ_LATENCY) step();

    // Back-to-back narrow reads while the wide port rewrites the same words
    a_vld_seen = 0;
    for (int n = 0; n < 24; n++) begin
      drive_a(1, 1, 0, 16 + n, '0, '0);
      drive_b(1, 0, 1, (16 + n) / 2, '1, rand_b());
      step();
    end
    idle();
    repeat (READ_LATENCY) step();
    chk("t6_valid_count", B_W'(a_vld_seen), B_W'(24));

    // Zero-fill with a read in flight and host traffic during the clear
    drive_a(1, 1, 0, int'($urandom_range(0, A_DEPTH - 1)), '0, '0);
    step();
    dut_wait = 0;
    dut_done = 0;
    clear_req = 1'b1;
    drive_a(1, 1, 0, 3, '0, '0);
    drive_b(1, 0, 1, 1, '1, rand_b());
    step();
    clear_req = 1'b0;
    for (int n = 0; n < B_DEPTH + 8 && (clr_pos >= 0 || done_pend); n++) begin
      drive_a(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), '1, rand_a());
      drive_b(1, 1, 0, int'($urandom_range(0, B_DEPTH - 1)), '0, '0);
      clear_req = (n == 5 || n == B_DEPTH);
      step();
    end
    clear_req = 1'b0;
    idle();
    repeat (READ_LATENCY) step();
    chk("t4_wait_cycles", B_W'(dut_wait), B_W'(B_DEPTH + 1));
    chk("t4_done_pulses", B_W'(dut_done), B_W'(1));
    for (int w = 0; w < B_DEPTH; w++) begin
      drive_b(1, 1, 0, w, '0, '0);
      step();
    end
    idle();
    repeat (READ_LATENCY) step();
    chk("t4_last_word_zero", b_readdata, '0);

    // Reset in the middle of a clear
    for (int w = 0; w < B_DEPTH; w++) begin
      d = rand_b();
      if (w == 10) saved10 = d;
      drive_b(1, 0, 1, w, '1, d);
      step();
    end
    idle();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    guard = 0;
    while (clr_pos != 10 && guard < 20) begin
      step();
      guard++;
    end
    chk("t5_reached_ptr10", B_W'(guard), B_W'(10));
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("t5_reset");
    aq.delete();
    bq.delete();
    clr_pos = -1;
    done_pend = 1'b0;
    coll = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("t5_no_done_in_reset", B_W'(clear_done), '0);
      chk("t5_no_busy_in_reset", B_W'(clear_busy), '0);
    end
    reset_n = 1'b1;
    dut_done = 0;
    for (int w = 0; w < B_DEPTH; w++) begin
      drive_b(1, 1, 0, w, '0, '0);
      step();
    end
    drive_b(1, 1, 0, 9, '0, '0);
    step();
    idle();
    repeat (READ_LATENCY - 1) step();
    chk("t5_word9_zero", b_readdata, '0);
    drive_b(1, 1, 0, 10, '0, '0);
    step();
    idle();
    repeat (READ_LATENCY - 1) step();
    chk("t5_word10_kept", b_readdata, saved10);
    chk("t5_no_done_after", B_W'(dut_done), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mixed_width_dpram_clr.md
Name: mixed_width_dpram_clr

Overview:
- Parametrised true dual-port on-chip RAM with two Avalon-MM slaves of different widths: narrow port A and wide port B, where B is A_DATA_W×B_RATIO bits.
- Successor to the fixed 128/256-bit matrix buffers in the accelerator.
- Adds:
  - honoured byte enables;
  - configurable read latency with readdatavalid;
  - defined same-cycle write-collision priority;
  - a hardware zero-fill (clear) engine so the host can reset an accumulation tile without bus traffic.

Parameters:
- A_DATA_W, 128, port A data width in bits; multiple of 8.
- B_RATIO, 2, port B width ÷ port A width; power of 2, range 1..8.
- A_DEPTH, 4096, port A words; power of 2; B_DEPTH = A_DEPTH/B_RATIO.
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2 (2 adds an output register).

Ports:
- clk  in  1  single clock for everything.
- reset_n  in  1  asynchronous, active-low reset.
- a_address  in  log2(A_DEPTH)  port A word address.
- a_chipselect, a_read, a_write  in  1 each  port A command.
- a_byteenable  in  A_DATA_W/8  port A byte lanes.
- a_writedata  in  A_DATA_W  port A write data.
- a_readdata  out  A_DATA_W  port A read data.
- a_readdatavalid  out  1  port A read data qualifier.
- a_waitrequest  out  1  port A stall.
- b_address  in  log2(B_DEPTH)  port B word address.
- b_chipselect, b_read, b_write  in  1 each  port B command.
- b_byteenable  in  A_DATA_W*B_RATIO/8  port B byte lanes.
- b_writedata  in  A_DATA_W*B_RATIO  port B write data.
- b_readdata  out  A_DATA_W*B_RATIO  port B read data.
- b_readdatavalid  out  1  port B read data qualifier.
- b_waitrequest  out  1  port B stall.
- clear_req  in  1  one-cycle pulse that starts the zero-fill.
- clear_busy  out  1  high while the zero-fill runs.
- clear_done  out  1  one-cycle pulse when the zero-fill completes.
- collision_count  out  16  write-collision statistic (see Optional Feature).

Behaviour:
- Storage: B_DEPTH words of B width.
  - A address maps to word = a_address >> log2(B_RATIO), lane = a_address[log2(B_RATIO)-1:0].
  - Lane 0 is the least-significant A_DATA_W bits.
- Accept rules:
  - A command is accepted when chipselect & (read|write) & !waitrequest.
  - read and write asserted together = write only.
- Writes: update only the bytes whose byteenable bit is 1. byteenable = 0 → no change.
- Reads:
  - Data returns exactly READ_LATENCY cycles after acceptance, with readdatavalid high for 1 cycle.
  - One read per cycle per port, fully pipelined.
- Read-during-write (same or other port, same word): read returns OLD data.
- Write collision: both ports write the same word in the same cycle with overlapping bytes.
  - Port A wins on overlapping bytes.
  - Port B's non-overlapping bytes are still written.
- Clear engine FSM, states IDLE → CLEAR → DONE → IDLE:
  - IDLE: clear_req → CLEAR; ptr = 0; clear_busy = 1.
  - CLEAR:
    - Writes an all-zero word at ptr each cycle; ptr increments.
    - At ptr = B_DEPTH-1, writes the final word, then → DONE.
    - Total B_DEPTH cycles.
  - DONE: clear_done = 1 for 1 cycle; clear_busy = 0; → IDLE.
  - clear_req in CLEAR or DONE is ignored; no restart.
  - a_waitrequest = b_waitrequest = clear_busy. No host access is accepted during clear.
  - Reads already in flight when a clear starts still complete with pre-clear data.
- Reset (asynchronous assert, synchronous-release assumed upstream):
  - FSM → IDLE, ptr = 0.
  - All valid pipeline bits cleared.
  - a/b_readdata = 0, readdatavalid = 0, waitrequest = 0, clear_busy = 0, clear_done = 0, collision_count = 0.
  - Memory contents are not reset.
  - Reset mid-clear aborts the clear and leaves a partially zeroed array; clear_done is not pulsed.
- Out-of-range parameters: elaboration-time fatal error.

Optional Feature:
- Macro: MPRAM_COLLISION_STAT_EN.
- Defined:
  - collision_count is a 16-bit counter.
  - Increments once per cycle in which both ports accept a write to the same word with overlapping byteenables.
  - Saturates at 16'hFFFF.
  - Cleared by reset and when the clear engine leaves IDLE.
- Undefined: collision_count is tied to 0 and the counter logic is absent. The port list is identical in both builds.

Decomposition:
- Package mpram_pkg holds:
  - clear FSM state enum (IDLE, CLEAR, DONE);
  - localparam functions clog2-based B_DEPTH / lane-width derivation;
  - collision counter width constant (16).
- One sub-module: mpram_rd_pipe, the per-port READ_LATENCY data/valid shift register with reset, instantiated twice with width parameter.

Test Plan:
1. Write A addr 5, data 128'h1111…, byteenable 16'hFFFF; read B addr 2 → b_readdata[255:128] = 128'h1111…, valid exactly READ_LATENCY cycles later.
2. Write B addr 0 with all-FF, then write B addr 0 with byteenable 32'h0000_000F, data 0 → read A addr 0 gives low 4 bytes 0, rest FF.
3. Same-cycle writes: A addr 1 (lane 1 of word 0) data 'hAA.., B word 0 data 'hBB.., full byteenables → word 0 = {A data, B low half}; collision_count = 1 with macro, 0 without.
4. Fill memory, pulse clear_req, issue reads during clear → waitrequest held for B_DEPTH+1 cycles, clear_done pulses once, then every read returns 0.
5. Assert reset_n low at ptr = 10 mid-clear → outputs reset, no clear_done; words ≥ 10 retain old data.
6. Back-to-back reads on A every cycle, READ_LATENCY = 2 → readdatavalid continuous, data in order, read-during-write returns old data.
